// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: register IDs, instruction codes and the default datapath width.
package y86_pkg;

  localparam int Y86_DATA_W = 64;

  // Register identifiers; 0xF is "no register" and is never stored.
  typedef logic [3:0] reg_id_t;

  localparam reg_id_t RRAX  = 4'h0;
  localparam reg_id_t RRCX  = 4'h1;
  localparam reg_id_t RRDX  = 4'h2;
  localparam reg_id_t RRBX  = 4'h3;
  localparam reg_id_t RRSP  = 4'h4;
  localparam reg_id_t RRBP  = 4'h5;
  localparam reg_id_t RRSI  = 4'h6;
  localparam reg_id_t RRDI  = 4'h7;
  localparam reg_id_t RR8   = 4'h8;
  localparam reg_id_t RR9   = 4'h9;
  localparam reg_id_t RR10  = 4'hA;
  localparam reg_id_t RR11  = 4'hB;
  localparam reg_id_t RR12  = 4'hC;
  localparam reg_id_t RR13  = 4'hD;
  localparam reg_id_t RR14  = 4'hE;
  localparam reg_id_t RNONE = 4'hF;

  localparam int NUM_REGS = 15;  // architectural registers 0..14
  localparam int NUM_IDS  = 16;  // full 4-bit ID space, including RNONE

  // Instruction codes, used by benches and neighbouring stages.
  typedef enum logic [3:0] {
    IHALT   = 4'h0,
    INOP    = 4'h1,
    IRRMOVQ = 4'h2,
    IIRMOVQ = 4'h3,
    IRMMOVQ = 4'h4,
    IMRMOVQ = 4'h5,
    IOPQ    = 4'h6,
    IJXX    = 4'h7,
    ICALL   = 4'h8,
    IRET    = 4'h9,
    IPUSHQ  = 4'hA,
    IPOPQ   = 4'hB
  } icode_t;

endpackage

// File: rtl/seq_regfile.sv
// Y86-64 SEQ program register file: two combinational read ports, a debug read port,
// two write ports (E and M) committed on the clock edge, and a saturating write counter.
module seq_regfile
  import y86_pkg::*;
#(
  parameter int                DATA_W    = Y86_DATA_W,
  parameter logic [DATA_W-1:0] RSP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [3:0]        srcA,
  input  logic [3:0]        srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [3:0]        dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [3:0]        dstM,
  input  logic [DATA_W-1:0] valM,
  input  logic [3:0]        dbg_idx,
  output logic [DATA_W-1:0] dbg_val,
  output logic [31:0]       wr_count
);

  // Whole ID space as a read view; slot RNONE is tied to zero so reads of 0xF yield 0
  // without any extra muxing.
  logic [DATA_W-1:0] regs [NUM_IDS];

  logic        e_wr;
  logic        m_wr;
  logic [1:0]  wr_inc;
  logic [32:0] cnt_sum;
  logic [31:0] wr_count_reg;
  logic [31:0] wr_count_next;

  // Decode the effective write strobes and how many distinct registers they touch.
  always_comb begin
    e_wr          = wr_en && (dstE != RNONE);
    m_wr          = wr_en && (dstM != RNONE);
    // A shared destination is a single register write.
    wr_inc        = 2'(e_wr) + 2'(m_wr && !(e_wr && (dstE == dstM)));
    cnt_sum       = {1'b0, wr_count_reg} + 33'(wr_inc);
    wr_count_next = cnt_sum[32] ? '1 : cnt_sum[31:0];
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg
      localparam logic [3:0]        ID   = 4'(gi);
      localparam logic [DATA_W-1:0] INIT = (gi == int'(RRSP)) ? RSP_RESET : '0;

      logic [DATA_W-1:0] q_reg;

      // Per-register commit; port M has priority so popq %rsp keeps the loaded value.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          q_reg <= INIT;
        end else if (m_wr && (dstM == ID)) begin
          q_reg <= valM;
        end else if (e_wr && (dstE == ID)) begin
          q_reg <= valE;
        end
      end

      assign regs[gi] = q_reg;
    end
  endgenerate

  assign regs[RNONE] = '0;

  // Saturating count of committed register writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_count_reg <= '0;
    end else begin
      wr_count_reg <= wr_count_next;
    end
  end

  // Reads see current state only; a same-cycle write shows up after the edge.
  assign valA     = regs[srcA];
  assign valB     = regs[srcB];
  assign dbg_val  = regs[dbg_idx];
  assign wr_count = wr_count_reg;

endmodule

// File: tb/tb_seq_regfile.sv
// Directed bench for seq_regfile: reset behaviour, a table of write/read vectors, and
// hand sequences for same-cycle read visibility and asynchronous reset.
module tb_seq_regfile;
  import y86_pkg::*;

  localparam int                DW  = 64;
  localparam logic [DW-1:0]     RSP = 64'h200;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [3:0]    srcA, srcB, dstE, dstM, dbg_idx;
  logic [DW-1:0] valA, valB, valE, valM, dbg_val;
  logic [31:0]   wr_count;

  int checks;
  int errors;

  seq_regfile #(.DATA_W(DW), .RSP_RESET(RSP)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .srcA     (srcA),
    .srcB     (srcB),
    .valA     (valA),
    .valB     (valB),
    .dstE     (dstE),
    .valE     (valE),
    .dstM     (dstM),
    .valM     (valM),
    .dbg_idx  (dbg_idx),
    .dbg_val  (dbg_val),
    .wr_count (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          we;
    logic [3:0]    de;
    logic [DW-1:0] ve;
    logic [3:0]    dm;
    logic [DW-1:0] vm;
    logic [3:0]    sa;
    logic [3:0]    sb;
    logic [3:0]    di;
    logic [DW-1:0] exp_a;
    logic [DW-1:0] exp_b;
    logic [DW-1:0] exp_d;
    logic [31:0]   exp_cnt;
  } vec_t;

  vec_t vecs [9];

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic we, input logic [3:0] de, input logic [DW-1:0] ve,
                       input logic [3:0] dm, input logic [DW-1:0] vm);
    wr_en = we;
    dstE  = de;
    valE  = ve;
    dstM  = dm;
    valM  = vm;
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Values written after the earlier hand sequence (reg2 = 0x55, count = 1).
    vecs[0] = '{1'b1, 4'h3, 64'h10,   4'h7, 64'hAB,   4'h3, 4'h7, 4'h2, 64'h10,   64'hAB,   64'h55,   32'd3};
    vecs[1] = '{1'b1, 4'h4, 64'h1F8,  4'h4, 64'h1234, 4'h4, 4'h2, 4'h7, 64'h1234, 64'h55,   64'hAB,   32'd4};
    vecs[2] = '{1'b0, 4'h5, 64'hFF,   4'hF, 64'h0,    4'h5, 4'h4, 4'h5, 64'h0,    64'h1234, 64'h0,    32'd4};
    vecs[3] = '{1'b1, 4'hF, 64'h77,   4'hF, 64'h88,   4'h5, 4'h3, 4'hF, 64'h0,    64'h10,   64'h0,    32'd4};
    vecs[4] = '{1'b1, 4'hF, 64'h0,    4'hE, 64'hDEAD, 4'hE, 4'hF, 4'hE, 64'hDEAD, 64'h0,    64'hDEAD, 32'd5};
    vecs[5] = '{1'b1, 4'h1, 64'h111,  4'hF, 64'h0,    4'h1, 4'hE, 4'h4, 64'h111,  64'hDEAD, 64'h1234, 32'd6};
    vecs[6] = '{1'b1, 4'hF, 64'h999,  4'h0, 64'h777,  4'h0, 4'hF, 4'h1, 64'h777,  64'h0,    64'h111,  32'd7};
    vecs[7] = '{1'b1, 4'h6, 64'hAAAA, 4'h8, 64'hBBBB, 4'h6, 4'h8, 4'h0, 64'hAAAA, 64'hBBBB, 64'h777,  32'd9};
    vecs[8] = '{1'b1, 4'h2, 64'h66,   4'h2, 64'h77,   4'h2, 4'h4, 4'h6, 64'h77,   64'h1234, 64'hAAAA, 32'd10};

    rst_n   = 1'b1;
    drive(1'b0, RNONE, '0, RNONE, '0);
    srcA    = RRSP;
    srcB    = RRAX;
    dbg_idx = RRSP;

    // Reset asserted between edges: outputs must follow without a clock edge.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("reset_valA_rsp", valA, RSP);
    check("reset_valB_rax", valB, '0);
    check("reset_dbg_rsp", dbg_val, RSP);
    check("reset_count", 64'(wr_count), '0);
    $display("txn reset: valA=%h valB=%h cnt=%0d", valA, valB, wr_count);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_valA_rsp", valA, RSP);
    check("idle_count", 64'(wr_count), '0);
    $display("txn idle: valA=%h cnt=%0d", valA, wr_count);

    // Same-cycle read of the register being written returns the old value.
    @(negedge clk);
    drive(1'b1, RRDX, 64'h55, RNONE, '0);
    srcA = RRDX;
    #1;
    check("pre_edge_valA", valA, '0);
    @(posedge clk);
    #1;
    check("post_edge_valA", valA, 64'h55);
    check("post_edge_count", 64'(wr_count), 64'd1);
    $display("txn write rdx: valA=%h cnt=%0d", valA, wr_count);

    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      drive(vecs[i].we, vecs[i].de, vecs[i].ve, vecs[i].dm, vecs[i].vm);
      srcA    = vecs[i].sa;
      srcB    = vecs[i].sb;
      dbg_idx = vecs[i].di;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_valA", i), valA, vecs[i].exp_a);
      check($sformatf("vec%0d_valB", i), valB, vecs[i].exp_b);
      check($sformatf("vec%0d_dbg", i), dbg_val, vecs[i].exp_d);
      check($sformatf("vec%0d_count", i), 64'(wr_count), 64'(vecs[i].exp_cnt));
      $display("txn vec%0d: we=%0b dstE=%h dstM=%h valA=%h valB=%h dbg=%h cnt=%0d",
               i, vecs[i].we, vecs[i].de, vecs[i].dm, valA, valB, dbg_val, wr_count);
    end

    // Asynchronous reset mid-cycle with a write pending: it must win over that edge.
    @(negedge clk);
    drive(1'b1, RRSP, 64'hCAFE, RRDX, 64'hBEEF);
    srcA    = RRSP;
    srcB    = RRDX;
    dbg_idx = RR14;
    #2;
    rst_n = 1'b0;
    #1;
    check("areset_valA_rsp", valA, RSP);
    check("areset_valB_rdx", valB, '0);
    check("areset_dbg_r14", dbg_val, '0);
    check("areset_count", 64'(wr_count), '0);
    @(posedge clk);
    #1;
    check("areset_hold_rsp", valA, RSP);
    check("areset_hold_rdx", valB, '0);
    dbg_idx = RNONE;
    #1;
    check("dbg_rnone", dbg_val, '0);
    $display("txn async reset: valA=%h valB=%h cnt=%0d", valA, valB, wr_count);

    // Writes resume normally after release.
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, RRSP, 64'h300, RNONE, '0);
    dbg_idx = RR8;
    @(posedge clk);
    #1;
    check("after_reset_rsp", valA, 64'h300);
    check("after_reset_r8", dbg_val, '0);
    check("after_reset_count", 64'(wr_count), 64'd1);
    $display("txn post-reset write: valA=%h cnt=%0d", valA, wr_count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_regfile.md
Name: seq_regfile

Overview:
- Y86-64 SEQ program register file. It sits directly downstream of the writeback stage, which supplies the destination IDs dstE/dstM.
- Commits valE/valM to the architectural registers on the clock edge.
- Serves the decode-stage reads valA/valB combinationally from srcA/srcB.
- Holds registers %rax..%r14 (IDs 0..14). ID 0xF (RNONE) means "no register".

Parameters:
- DATA_W, 64, register width in bits
- RSP_RESET, 64'h0, reset value of %rsp (ID 4); all other registers reset to 0

Ports:
- clk  input  1  system clock; all updates on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  commit enable; low when the pipeline status is not AOK (halt, adr, ins) or the stage is stalled
- srcA  input  4  read-port A register ID
- srcB  input  4  read-port B register ID
- valA  output  DATA_W  contents of srcA; 0 when srcA = RNONE
- valB  output  DATA_W  contents of srcB; 0 when srcB = RNONE
- dstE  input  4  write-port E register ID, from writeback
- valE  input  DATA_W  write-port E data (ALU result)
- dstM  input  4  write-port M data register ID, from writeback
- valM  input  DATA_W  write-port M data (memory read)
- dbg_idx  input  4  debug read index
- dbg_val  output  DATA_W  contents of dbg_idx; 0 for 0xF
- wr_count  output  32  number of register writes committed since reset, saturating

Behaviour:
- Reset: rst_n low asynchronously forces
  - all 15 registers to 0, except %rsp to RSP_RESET;
  - wr_count to 0.
  - Outputs follow immediately, because reads are combinational from the registers.
- Reset release: state changes only on a rising clk edge with rst_n high. Reset asserted mid-operation overrides any write pending on that edge.
- Reads: valA/valB/dbg_val are purely combinational from current register state.
  - No write-through bypass. A read of a register being written this cycle returns the old value. The new value is visible after the edge (SEQ semantics).
- Write on rising edge, only if wr_en = 1:
  - if dstE != 0xF: reg[dstE] <= valE
  - if dstM != 0xF: reg[dstM] <= valM
  - dstE == dstM (both != 0xF): valM wins. This is the popq %rsp case: %rsp gets the memory value, not the incremented pointer.
- wr_en = 0: no register changes and wr_count holds, regardless of dstE/dstM.
- wr_count: increments by the number of distinct registers actually written this edge (0, 1 or 2).
  - The dstE == dstM collision counts as 1.
  - Saturates at 32'hFFFF_FFFF; no wrap.
- IDs are 4-bit, so no out-of-range case exists. 0xF is the only no-op ID and is never stored.
- Latency: write-to-read visibility is 1 clock; read latency is 0 (combinational).

Decomposition:
- Shared package y86_pkg holds:
  - register ID constants RRAX=0 .. RR14=14, RRSP=4, RNONE=4'hF;
  - icode constants (IHALT..IPOPQ), for bench use;
  - DATA_W default.
- The module is implemented as a single block (15-entry register array, write-arbitration logic, counter); no sub-module.

Test Plan:
- Reset with RSP_RESET=64'h200: rst_n low mid-cycle → valA(srcA=4)=0x200 immediately, valB(srcB=0)=0, wr_count=0; release, no writes → values hold.
- dstE=2, valE=0x55, dstM=0xF, wr_en=1; srcA=2 same cycle → valA=0 before the edge, 0x55 after it; wr_count=1.
- dstE=3, valE=0x10, dstM=7, valM=0xAB → reg3=0x10, reg7=0xAB after one edge; wr_count +2.
- Collision: dstE=4, valE=0x1F8, dstM=4, valM=0x1234 → %rsp=0x1234; wr_count +1.
- wr_en=0 with dstE=5, valE=0xFF → reg5 unchanged, wr_count unchanged; dstE=dstM=0xF with wr_en=1 → no change.
- Async reset asserted between clock edges after writes → all registers 0 and %rsp=RSP_RESET without waiting for clk; dbg_idx=0xF → dbg_val=0.
